decode_dispatch_queue: RTL and testbench
========================================

Name: decode_dispatch_queue

Overview:
- Parametrised successor to the single-instruction combinational decoder in the Tomasulo front end.
- Accepts RV32 instructions over a valid/ready handshake and decodes them at enqueue into unit class, register specifiers and immediate.
- Buffers decoded entries in an in-order FIFO of DEPTH entries.
- Dispatches the head entry to the reservation station of its class only when that station signals ready. Supports flush and counts illegal instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- NUM_CLASS, 4, number of functional-unit classes; fixed encoding: 0=ALU, 1=MUL, 2=LOAD, 3=STORE.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear (mispredict/exception)
- in_valid  input  1  instruction offered
- in_ready  output  1  queue can accept
- instruction  input  32  raw instruction word
- rs_ready  input  NUM_CLASS  per-class reservation-station free slot
- disp_valid  output  1  head entry valid
- disp_class  output  2  class of head entry
- disp_rd  output  5  destination register
- disp_rs1  output  5  source 1
- disp_rs2  output  5  source 2
- disp_uses_rd  output  1  head writes a register (rd != 0)
- disp_uses_rs2  output  1  head reads rs2
- disp_imm  output  32  sign-extended immediate (I or S type), 0 for R-type
- disp_lwsw  output  1  1=load, 0=store; valid only for mem classes
- disp_fire  output  1  head dispatched this cycle
- occupancy  output  $clog2(DEPTH+1)  valid entries
- illegal_cnt  output  CNT_W  illegal instructions dropped

Behaviour:
- Reset (async, rst_n=0):
  - Head and tail pointers and occupancy go to 0; illegal_cnt goes to 0.
  - disp_valid=0, disp_fire=0, in_ready=1.
  - Entry payload contents are don't-care.
- Decode happens at enqueue; opcode = instruction[6:0].
  - 0000011 LOAD: class 2, lwsw=1, rd/rs1 taken from the instruction, uses_rs2=0, imm = sext(instr[31:20]).
  - 0100011 STORE: class 3, lwsw=0, rs1/rs2 taken from the instruction, uses_rd=0, uses_rs2=1, imm = sext({instr[31:25], instr[11:7]}).
  - 0110011 OP: funct7 = 0000001 gives class 1 (MUL); otherwise class 0 (ALU). rd/rs1/rs2 taken from the instruction, uses_rs2=1, imm=0.
  - 0010011 OP-IMM: class 0, rd/rs1 taken from the instruction, uses_rs2=0, imm = sext(instr[31:20]).
  - Unused specifier fields are driven to 0.
  - uses_rd = 0 whenever rd == 0.
  - Any other opcode is illegal.
- Enqueue:
  - in_ready = (occupancy != DEPTH) and !flush. There is no same-cycle pass-through when full.
  - Handshake completes when in_valid && in_ready.
  - Legal instruction: written at the tail; tail increments and wraps modulo DEPTH.
  - Illegal instruction: handshake completes, nothing is stored, illegal_cnt increments and saturates at all-ones.
- Dispatch:
  - disp_valid = (occupancy != 0). All disp_* fields are driven combinationally from the head entry.
  - disp_fire = disp_valid && rs_ready[disp_class]. On fire, head increments and wraps.
  - Head entry and its outputs must remain stable until it fires.
- Latency: an instruction accepted at edge N is presented at the head in the cycle after edge N at the earliest. Decode has no bypass to dispatch.
- Simultaneous enqueue and dispatch: occupancy is unchanged and both pointers advance.
- Empty: disp_valid=0, disp_fire=0, and disp_* fields are don't-care.
- Full: in_ready=0. A dispatch in that cycle frees one slot, usable from the next cycle.
- Flush (flush=1 at an edge):
  - Occupancy and both pointers go to 0.
  - in_ready is 0 in the flush cycle, so no enqueue occurs.
  - disp_fire is forced to 0 in the flush cycle.
  - illegal_cnt is preserved.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first enqueue is possible in the first cycle after rst_n deasserts.
- occupancy is registered, in the range 0..DEPTH.

Test Plan:
- Reset then enqueue LOAD 0x00412083 (lw x1,4(x2)), rs_ready=4'b0100: cycle +1 shows disp_valid=1, class=2, rd=1, rs1=2, imm=4, lwsw=1, disp_fire=1; occupancy returns to 0.
- Enqueue ADD 0x003100B3 then MUL 0x023100B3 with rs_ready[1]=0: ADD fires, MUL holds at the head with stable outputs; raising rs_ready[1] makes MUL fire with class=1.
- Enqueue 5 ALU ops with rs_ready=0 and DEPTH=4: in_ready drops after the 4th (occupancy=4); 5th is held by the source. One dispatch, then in_ready=1 the next cycle.
- Enqueue opcode 1111111 three times: in_ready stays 1, occupancy stays 0, illegal_cnt=3; with CNT_W=2, five illegal ops saturate the counter at 3.
- Fill 3 entries, assert flush together with in_valid=1: occupancy=0, disp_valid=0, the offered instruction is not accepted, illegal_cnt is unchanged.
- Store 0x0020A423 (sw x2,8(x1)) with rd field nonzero: class=3, uses_rd=0, rs1=1, rs2=2, imm=8, lwsw=0. Pointer wrap is checked by issuing 2*DEPTH+1 interleaved ops with in-order dispatch.

Source files
------------

// File: rtl/decode_dispatch_queue.sv
// Decode-at-enqueue instruction queue: RV32 words are decoded into class, register
// specifiers and immediate, buffered in order, and dispatched to per-class stations.
module decode_dispatch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_CLASS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  instruction,
  input  logic [NUM_CLASS-1:0]         rs_ready,
  output logic                         disp_valid,
  output logic [1:0]                   disp_class,
  output logic [4:0]                   disp_rd,
  output logic [4:0]                   disp_rs1,
  output logic [4:0]                   disp_rs2,
  output logic                         disp_uses_rd,
  output logic                         disp_uses_rs2,
  output logic [31:0]                  disp_imm,
  output logic                         disp_lwsw,
  output logic                         disp_fire,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             illegal_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [1:0] CLS_ALU   = 2'd0;
  localparam logic [1:0] CLS_MUL   = 2'd1;
  localparam logic [1:0] CLS_LOAD  = 2'd2;
  localparam logic [1:0] CLS_STORE = 2'd3;

  typedef struct packed {
    logic [1:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rd;
    logic        uses_rs2;
    logic [31:0] imm;
    logic        lwsw;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             dec;
  entry_t             head;
  logic               dec_legal;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               push;

  // funct3 does not influence class or operands in this decoder
  logic unused_funct3;
  assign unused_funct3 = ^instruction[14:12];

  // Full decode of the offered word; unused specifiers stay zero
  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    case (instruction[6:0])
      OPC_LOAD: begin
        dec_legal = 1'b1;
        dec.cls   = CLS_LOAD;
        dec.lwsw  = 1'b1;
        dec.rd    = instruction[11:7];
        dec.rs1   = instruction[19:15];
        dec.imm   = {{20{instruction[31]}}, instruction[31:20]};
      end
      OPC_STORE: begin
        dec_legal    = 1'b1;
        dec.cls      = CLS_STORE;
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.uses_rs2 = 1'b1;
        dec.imm      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_OP: begin
        dec_legal    = 1'b1;
        dec.cls      = (instruction[31:25] == F7_MULDIV) ? CLS_MUL : CLS_ALU;
        dec.rd       = instruction[11:7];
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec.cls   = CLS_ALU;
        dec.rd    = instruction[11:7];
        dec.rs1   = instruction[19:15];
        dec.imm   = {{20{instruction[31]}}, instruction[31:20]};
      end
      default: ;
    endcase
    dec.uses_rd = (dec.rd != 5'd0);
  end

  assign head       = mem_q[head_q];
  assign in_ready   = (occ_q != OCC_W'(DEPTH)) && !flush;
  assign disp_valid = (occ_q != '0);
  assign disp_fire  = disp_valid && !flush && rs_ready[head.cls];
  assign accept     = in_valid && in_ready;
  assign push       = accept && dec_legal;

  // Pointer, occupancy and illegal-counter next state
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (disp_fire) head_d = head_q + PTR_W'(1);
      if (push)      tail_d = tail_q + PTR_W'(1);
      case ({push, disp_fire})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
    if (accept && !dec_legal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy qualifies every entry
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec;
  end

  assign disp_class    = head.cls;
  assign disp_rd       = head.rd;
  assign disp_rs1      = head.rs1;
  assign disp_rs2      = head.rs2;
  assign disp_uses_rd  = head.uses_rd;
  assign disp_uses_rs2 = head.uses_rs2;
  assign disp_imm      = head.imm;
  assign disp_lwsw     = head.lwsw;
  assign occupancy     = occ_q;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Bench for decode_dispatch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_decode_dispatch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_CLASS = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned OCC_W     = $clog2(DEPTH + 1);
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  localparam logic [31:0] I_LW  = 32'h00412083;
  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_SW  = 32'h0020A423;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instruction;
  logic [NUM_CLASS-1:0] rs_ready;
  logic                 disp_valid;
  logic [1:0]           disp_class;
  logic [4:0]           disp_rd;
  logic [4:0]           disp_rs1;
  logic [4:0]           disp_rs2;
  logic                 disp_uses_rd;
  logic                 disp_uses_rs2;
  logic [31:0]          disp_imm;
  logic                 disp_lwsw;
  logic                 disp_fire;
  logic [OCC_W-1:0]     occupancy;
  logic [CNT_W-1:0]     illegal_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_dispatch_queue #(.DEPTH(DEPTH), .NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .rs_ready(rs_ready), .disp_valid(disp_valid),
    .disp_class(disp_class), .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_uses_rd(disp_uses_rd), .disp_uses_rs2(disp_uses_rs2), .disp_imm(disp_imm),
    .disp_lwsw(disp_lwsw), .disp_fire(disp_fire), .occupancy(occupancy),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    int          cls;
    int          rd;
    int          rs1;
    int          rs2;
    bit          uses_rd;
    bit          uses_rs2;
    logic [31:0] imm;
    bit          lwsw;
  } ent_t;

  ent_t mq[$];
  int   m_ill = 0;

  // Reference decode written straight from the instruction-format rules
  function automatic bit ref_decode(input logic [31:0] ins, output ent_t e);
    e.cls = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.uses_rd = 0; e.uses_rs2 = 0; e.imm = 32'd0; e.lwsw = 0;
    case (ins[6:0])
      7'b0000011: begin
        e.cls = 2; e.lwsw = 1; e.rd = int'(ins[11:7]); e.rs1 = int'(ins[19:15]);
        e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        e.cls = 3; e.rs1 = int'(ins[19:15]); e.rs2 = int'(ins[24:20]); e.uses_rs2 = 1;
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0110011: begin
        e.cls = (ins[31:25] == 7'b0000001) ? 1 : 0;
        e.rd = int'(ins[11:7]); e.rs1 = int'(ins[19:15]); e.rs2 = int'(ins[24:20]);
        e.uses_rs2 = 1;
      end
      7'b0010011: begin
        e.rd = int'(ins[11:7]); e.rs1 = int'(ins[19:15]);
        e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      default: return 1'b0;
    endcase
    e.uses_rd = (e.rd != 0);
    return 1'b1;
  endfunction

  function automatic bit m_in_ready();
    return (mq.size() != DEPTH) && !flush;
  endfunction

  function automatic bit m_fire();
    if (mq.size() == 0 || flush) return 1'b0;
    return rs_ready[mq[0].cls];
  endfunction

  function automatic logic [31:0] addi_x1(input int k);
    return 32'h00000093 | (32'(k) << 20);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000001; end
      3: r[6:0] = 7'b0110011;
      4: r[6:0] = 7'b0010011;
      5: begin r[6:0] = 7'b0010011; r[11:7] = 5'd0; end
      default: r[6:0] = 7'($urandom);
    endcase
    return r;
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [3:0] rdy, input bit fl);
    in_valid    = v;
    instruction = ins;
    rs_ready    = rdy;
    flush       = fl;
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    bit   acc;
    bit   fire;
    ent_t e;
    acc  = in_valid && m_in_ready();
    fire = m_fire();
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (fire) void'(mq.pop_front());
      if (acc) begin
        if (ref_decode(instruction, e)) mq.push_back(e);
        else if (m_ill < CNT_MAX) m_ill++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 32'd0, 4'b1111, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
    checks++; if (disp_fire !== 1'b0) begin errors++; $display("FAIL reset_disp_fire got=%b exp=0", disp_fire); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (illegal_cnt !== '0) begin errors++; $display("FAIL reset_illegal_cnt got=%0d exp=0", illegal_cnt); end
    rst_n = 1'b1;
    mq.delete(); m_ill = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    drive(1, I_LW, 4'b0100, 0);
    @(negedge clk);
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL load_no_bypass got=%b exp=0", disp_valid); end
    tick();
    drive(0, 32'd0, 4'b0100, 0);
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL load_valid got=%b exp=1", disp_valid); end
    checks++; if (disp_class !== 2'd2) begin errors++; $display("FAIL load_class got=%0d exp=2", disp_class); end
    checks++; if (disp_rd !== 5'd1 || disp_rs1 !== 5'd2) begin errors++; $display("FAIL load_regs got rd=%0d rs1=%0d exp rd=1 rs1=2", disp_rd, disp_rs1); end
    checks++; if (disp_imm !== 32'd4) begin errors++; $display("FAIL load_imm got=%0d exp=4", disp_imm); end
    checks++; if (disp_lwsw !== 1'b1 || disp_uses_rs2 !== 1'b0 || disp_uses_rd !== 1'b1) begin errors++; $display("FAIL load_flags got lwsw=%b urs2=%b urd=%b exp 1 0 1", disp_lwsw, disp_uses_rs2, disp_uses_rd); end
    checks++; if (disp_fire !== 1'b1) begin errors++; $display("FAIL load_fire got=%b exp=1", disp_fire); end
    tick();
    drive(0, 32'd0, 4'b0000, 0);
    @(negedge clk);
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL load_occ_after got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_mul_hold();
    drive(1, I_ADD, 4'b1101, 0); @(negedge clk); tick();
    drive(1, I_MUL, 4'b1101, 0); @(negedge clk);
    checks++; if (disp_class !== 2'd0 || disp_fire !== 1'b1) begin errors++; $display("FAIL add_fire got cls=%0d fire=%b exp cls=0 fire=1", disp_class, disp_fire); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 4'b1101, 0); @(negedge clk);
      checks++;
      if (disp_valid !== 1'b1 || disp_class !== 2'd1 || disp_fire !== 1'b0 || disp_rd !== 5'd1 ||
          disp_rs1 !== 5'd2 || disp_rs2 !== 5'd3 || disp_imm !== 32'd0) begin
        errors++;
        $display("FAIL mul_hold i=%0d got v=%b cls=%0d fire=%b rd=%0d rs1=%0d rs2=%0d imm=%0d exp 1 1 0 1 2 3 0",
                 i, disp_valid, disp_class, disp_fire, disp_rd, disp_rs1, disp_rs2, disp_imm);
      end
      tick();
    end
    drive(0, 32'd0, 4'b0010, 0); @(negedge clk);
    checks++; if (disp_class !== 2'd1 || disp_fire !== 1'b1) begin errors++; $display("FAIL mul_fire got cls=%0d fire=%b exp cls=1 fire=1", disp_class, disp_fire); end
    tick();
    drive(0, 32'd0, 4'b0000, 0); @(negedge clk);
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL mul_occ_after got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) begin
      drive(1, addi_x1(k), 4'b0000, 0); @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
    end
    drive(1, addi_x1(5), 4'b0000, 0); @(negedge clk);
    checks++; if (in_ready !== 1'b0 || occupancy !== OCC_W'(4)) begin errors++; $display("FAIL full_stall got rdy=%b occ=%0d exp rdy=0 occ=4", in_ready, occupancy); end
    tick();
    drive(1, addi_x1(5), 4'b0001, 0); @(negedge clk);
    checks++; if (disp_fire !== 1'b1 || in_ready !== 1'b0 || disp_imm !== 32'd1) begin errors++; $display("FAIL full_dispatch got fire=%b rdy=%b imm=%0d exp 1 0 1", disp_fire, in_ready, disp_imm); end
    tick();
    drive(1, addi_x1(5), 4'b0000, 0); @(negedge clk);
    checks++; if (in_ready !== 1'b1 || occupancy !== OCC_W'(3)) begin errors++; $display("FAIL full_reopen got rdy=%b occ=%0d exp rdy=1 occ=3", in_ready, occupancy); end
    tick();
    for (int k = 2; k <= 5; k++) begin
      drive(0, 32'd0, 4'b1111, 0); @(negedge clk);
      checks++; if (disp_fire !== 1'b1 || disp_imm !== 32'(k)) begin errors++; $display("FAIL full_drain_order got fire=%b imm=%0d exp fire=1 imm=%0d", disp_fire, disp_imm, k); end
      tick();
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      drive(1, I_BAD, 4'b0000, 0); @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready i=%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    drive(0, 32'd0, 4'b0000, 0); @(negedge clk);
    checks++; if (occupancy !== '0 || illegal_cnt !== CNT_W'(3)) begin errors++; $display("FAIL illegal_count got occ=%0d cnt=%0d exp occ=0 cnt=3", occupancy, illegal_cnt); end
    tick();
  endtask

  task automatic test_store();
    drive(1, I_SW, 4'b0000, 0); @(negedge clk); tick();
    drive(0, 32'd0, 4'b0000, 0); @(negedge clk);
    checks++; if (disp_class !== 2'd3 || disp_uses_rd !== 1'b0 || disp_rd !== 5'd0) begin errors++; $display("FAIL store_class got cls=%0d urd=%b rd=%0d exp 3 0 0", disp_class, disp_uses_rd, disp_rd); end
    checks++; if (disp_rs1 !== 5'd1 || disp_rs2 !== 5'd2 || disp_uses_rs2 !== 1'b1) begin errors++; $display("FAIL store_regs got rs1=%0d rs2=%0d urs2=%b exp 1 2 1", disp_rs1, disp_rs2, disp_uses_rs2); end
    checks++; if (disp_imm !== 32'd8 || disp_lwsw !== 1'b0) begin errors++; $display("FAIL store_imm got imm=%0d lwsw=%b exp imm=8 lwsw=0", disp_imm, disp_lwsw); end
    tick();
    drive(0, 32'd0, 4'b1000, 0); @(negedge clk); tick();
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      drive(1, addi_x1(k), 4'b0000, 0); @(negedge clk); tick();
    end
    drive(1, I_ADD, 4'b1111, 1); @(negedge clk);
    checks++; if (in_ready !== 1'b0 || disp_fire !== 1'b0) begin errors++; $display("FAIL flush_cycle got rdy=%b fire=%b exp 0 0", in_ready, disp_fire); end
    tick();
    drive(0, 32'd0, 4'b0000, 0); @(negedge clk);
    checks++; if (occupancy !== '0 || disp_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got occ=%0d v=%b exp 0 0", occupancy, disp_valid); end
    checks++; if (illegal_cnt !== CNT_W'(3)) begin errors++; $display("FAIL flush_cnt_kept got=%0d exp=3", illegal_cnt); end
    tick();
  endtask

  task automatic test_random();
    bit   exp_rdy;
    bit   exp_fire;
    ent_t h;
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 3) != 0), rand_instr(), 4'($urandom), ($urandom_range(0, 39) == 0));
      @(negedge clk);
      exp_rdy  = m_in_ready();
      exp_fire = m_fire();
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      checks++; if (disp_fire !== exp_fire) begin errors++; $display("FAIL rnd_fire c=%0d got=%b exp=%b", c, disp_fire, exp_fire); end
      checks++; if (occupancy !== OCC_W'(mq.size())) begin errors++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, mq.size()); end
      checks++; if (illegal_cnt !== CNT_W'(m_ill)) begin errors++; $display("FAIL rnd_illegal_cnt c=%0d got=%0d exp=%0d", c, illegal_cnt, m_ill); end
      checks++; if (disp_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, disp_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        h = mq[0];
        checks++;
        if (disp_class !== 2'(h.cls) || disp_rd !== 5'(h.rd) || disp_rs1 !== 5'(h.rs1) ||
            disp_rs2 !== 5'(h.rs2) || disp_uses_rd !== h.uses_rd || disp_uses_rs2 !== h.uses_rs2 ||
            disp_imm !== h.imm || (h.cls >= 2 && disp_lwsw !== h.lwsw)) begin
          errors++;
          $display("FAIL rnd_head c=%0d got cls=%0d rd=%0d rs1=%0d rs2=%0d urd=%b urs2=%b imm=%h lwsw=%b exp cls=%0d rd=%0d rs1=%0d rs2=%0d urd=%b urs2=%b imm=%h lwsw=%b",
                   c, disp_class, disp_rd, disp_rs1, disp_rs2, disp_uses_rd, disp_uses_rs2, disp_imm, disp_lwsw,
                   h.cls, h.rd, h.rs1, h.rs2, h.uses_rd, h.uses_rs2, h.imm, h.lwsw);
        end
      end
      tick();
    end
    drive(0, 32'd0, 4'b0000, 1); @(negedge clk); tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(1, I_BAD, 4'b0000, 0); @(negedge clk); tick();
    end
    drive(0, 32'd0, 4'b0000, 0); @(negedge clk);
    checks++; if (illegal_cnt !== CNT_W'(CNT_MAX) || m_ill != CNT_MAX) begin errors++; $display("FAIL illegal_saturate got=%0d exp=%0d", illegal_cnt, CNT_MAX); end
    checks++; if (in_ready !== 1'b1 || occupancy !== '0) begin errors++; $display("FAIL illegal_sat_state got rdy=%b occ=%0d exp 1 0", in_ready, occupancy); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 2; k++) begin
      drive(1, addi_x1(k), 4'b0000, 0); @(negedge clk); tick();
    end
    drive(0, 32'd0, 4'b0000, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (occupancy !== '0 || disp_valid !== 1'b0 || illegal_cnt !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got occ=%0d v=%b cnt=%0d rdy=%b exp 0 0 0 1", occupancy, disp_valid, illegal_cnt, in_ready); end
    mq.delete(); m_ill = 0;
    @(negedge clk); rst_n = 1'b1;
    drive(1, I_LW, 4'b0000, 0);
    @(posedge clk); #1;
    checks++; if (occupancy !== OCC_W'(1) || disp_rd !== 5'd1) begin errors++; $display("FAIL reset_first_enq got occ=%0d rd=%0d exp occ=1 rd=1", occupancy, disp_rd); end
    drive(0, 32'd0, 4'b0000, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_mul_hold();
    test_full();
    test_illegal();
    test_store();
    test_flush();
    test_random();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
